wb_stream_buffer: RTL

- Per-channel weight-buffer stage downstream of the PU weight-buffer SRAM controller; one instance each for the idx, repetition and unique streams of every input channel.
- Requests SRAM words through a read/ready handshake and exposes the current word index for address generation.
- Captures each returned word and serializes it into fixed-width elements for the PE datapath over a valid/ready interface.

---
 rtl/wb_stream_buffer_pkg.sv | 33 +++
 rtl/wb_stream_buffer_if.sv | 46 ++++
 rtl/wb_stream_buffer_serializer.sv | 72 +++++++
 rtl/wb_stream_buffer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_stream_buffer_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg : shared definitions for the weight-buffer stream stage.
//
// Contents
//   wb_stream_state_t : FSM state encoding (IDLE, FETCH, STREAM, DONE)
//   WB_WORD_WIDTH     : default SRAM word width
//   WB_ELEM_WIDTH     : default element width
//   words_for_elems() : number of SRAM words needed to hold n elements
// -----------------------------------------------------------------------------
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } wb_stream_state_t;

   localparam int WB_WORD_WIDTH = 32;
   localparam int WB_ELEM_WIDTH = 8;

   // ceil(n / elems_per_word), written without n + epw - 1 so that it
   // cannot overflow for element counts close to 2^32.
   function automatic logic [31:0] words_for_elems(
      input logic [31:0] n,
      input int unsigned elems_per_word = WB_WORD_WIDTH / WB_ELEM_WIDTH
   );
      logic [31:0] epw;
      epw = elems_per_word;
      words_for_elems = (n / epw) + (((n % epw) != 32'd0) ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/wb_stream_buffer_if.sv
// -----------------------------------------------------------------------------
// wb_stream_buffer_if : bus bundle between the weight-buffer stream stage,
// its SRAM controller and the PE-side element consumer.
//
// Signals
//   start, num_elems            : stream launch request and element count
//   word_read, word_counter     : SRAM word request and its word index
//   word_ready, sram_word_in    : SRAM return pulse and shared read data
//   elem_valid, elem_data,
//   elem_ready                  : element valid/ready stream to the PE
//   busy, done                  : status
//
// Modports
//   slave  : the stream-buffer side (wb_stream_buffer)
//   master : the environment side (controller, consumer, sequencer)
// -----------------------------------------------------------------------------
interface wb_stream_buffer_if
   import wb_pkg::*;
#(
   parameter int WORD_WIDTH = WB_WORD_WIDTH,
   parameter int ELEM_WIDTH = WB_ELEM_WIDTH
) ();

   logic                  start;
   logic [31:0]           num_elems;
   logic                  word_read;
   logic [31:0]           word_counter;
   logic                  word_ready;
   logic [WORD_WIDTH-1:0] sram_word_in;
   logic                  elem_valid;
   logic [ELEM_WIDTH-1:0] elem_data;
   logic                  elem_ready;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, num_elems, word_ready, sram_word_in, elem_ready,
      output word_read, word_counter, elem_valid, elem_data, busy, done
   );

   modport master (
      output start, num_elems, word_ready, sram_word_in, elem_ready,
      input  word_read, word_counter, elem_valid, elem_data, busy, done
   );

endinterface

// File: rtl/wb_stream_buffer_serializer.sv
// -----------------------------------------------------------------------------
// wb_word_serializer : holds one SRAM word and presents it element by element
// (element 0 in the LSBs) on a valid/ready interface.
//
// Ports
//   clock, reset   : clock, synchronous active-high reset
//   load_i         : load word_i, restart at element 0, raise valid
//   word_i         : word to load
//   stop_i         : drop valid (ignored when load_i is high)
//   elem_ready_i   : consumer ready
//   elem_valid_o   : element valid
//   elem_data_o    : current element
//   fire_o         : handshake this cycle (valid && ready)
//   last_o         : current element is the top element of the word
// -----------------------------------------------------------------------------
module wb_word_serializer
   import wb_pkg::*;
#(
   parameter int WORD_WIDTH = WB_WORD_WIDTH,
   parameter int ELEM_WIDTH = WB_ELEM_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [WORD_WIDTH-1:0] word_i,
   input  logic                  stop_i,
   input  logic                  elem_ready_i,
   output logic                  elem_valid_o,
   output logic [ELEM_WIDTH-1:0] elem_data_o,
   output logic                  fire_o,
   output logic                  last_o
);

   localparam int ELEMS_PER_WORD = WORD_WIDTH / ELEM_WIDTH;
   localparam int IDX_W          = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;

   logic [WORD_WIDTH-1:0] word_q;
   logic [IDX_W-1:0]      elem_idx_q;
   logic                  elem_valid_q;
   logic [ELEM_WIDTH-1:0] elems [ELEMS_PER_WORD];

   for (genvar gi = 0; gi < ELEMS_PER_WORD; gi++) begin : g_elem
      assign elems[gi] = word_q[gi*ELEM_WIDTH +: ELEM_WIDTH];
   end

   assign elem_valid_o = elem_valid_q;
   assign elem_data_o  = elems[elem_idx_q];
   assign fire_o       = elem_valid_q && elem_ready_i;
   assign last_o       = (elem_idx_q == IDX_W'(ELEMS_PER_WORD - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         word_q       <= '0;
         elem_idx_q   <= '0;
         elem_valid_q <= 1'b0;
      end else begin
         // The index wraps naturally at the word boundary because
         // ELEMS_PER_WORD is a power of two.
         if (fire_o) begin
            elem_idx_q <= elem_idx_q + IDX_W'(1);
         end
         if (load_i) begin
            word_q       <= word_i;
            elem_idx_q   <= '0;
            elem_valid_q <= 1'b1;
         end else if (stop_i) begin
            elem_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_stream_buffer.sv
// -----------------------------------------------------------------------------
// wb_stream_buffer : per-channel weight-buffer stream stage. Fetches SRAM
// words through a read/ready handshake and serializes them into elements
// for the PE datapath.
//
// Ports
//   clock, reset : clock, synchronous active-high reset
//   bus          : wb_stream_buffer_if.slave (start/num_elems, word_read/
//                  word_counter, word_ready/sram_word_in, elem_valid/
//                  elem_data/elem_ready, busy/done)
//
// Build option
//   WB_STREAM_PREFETCH_EN : adds a one-word prefetch slot so the next word is
//   requested while the current one drains; a full slot is promoted to the
//   active word at the boundary with no bubble. Undefined: every word
//   boundary goes through FETCH.
// -----------------------------------------------------------------------------
module wb_stream_buffer
   import wb_pkg::*;
#(
   parameter int WORD_WIDTH = WB_WORD_WIDTH,
   parameter int ELEM_WIDTH = WB_ELEM_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   wb_stream_buffer_if.slave    bus
);

   wb_stream_state_t      state_q;
   logic                  word_read_q;
   logic [31:0]           word_counter_q;
   logic [31:0]           remaining_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  capture;
   logic                  at_end;
   logic                  at_boundary;
   logic                  ser_load;
   logic                  ser_stop;
   logic                  ser_fire;
   logic                  ser_last;
   logic [WORD_WIDTH-1:0] ser_word;

   // A return pulse only counts while a request is outstanding; stale pulses
   // and pulses after a reset are dropped here.
   assign capture     = word_read_q && bus.word_ready;
   assign at_end      = ser_fire && (remaining_q == 32'd1);
   assign at_boundary = ser_fire && ser_last && (remaining_q != 32'd1);

`ifdef WB_STREAM_PREFETCH_EN
   localparam int ELEMS_PER_WORD = WORD_WIDTH / ELEM_WIDTH;

   logic [WORD_WIDTH-1:0] slot_q;
   logic                  slot_full_q;
   logic [31:0]           total_words_q;

   // At a boundary the next word comes from the slot, or straight from the
   // SRAM when it happens to land on that very edge.
   assign ser_load = ((state_q == FETCH) && capture)
                   || (at_boundary && (slot_full_q || capture));
   assign ser_word = slot_full_q ? slot_q : bus.sram_word_in;
`else
   assign ser_load = (state_q == FETCH) && capture;
   assign ser_word = bus.sram_word_in;
`endif

   assign ser_stop = at_end || (at_boundary && !ser_load);

   wb_word_serializer #(
      .WORD_WIDTH (WORD_WIDTH),
      .ELEM_WIDTH (ELEM_WIDTH)
   ) u_serializer (
      .clock        (clock),
      .reset        (reset),
      .load_i       (ser_load),
      .word_i       (ser_word),
      .stop_i       (ser_stop),
      .elem_ready_i (bus.elem_ready),
      .elem_valid_o (bus.elem_valid),
      .elem_data_o  (bus.elem_data),
      .fire_o       (ser_fire),
      .last_o       (ser_last)
   );

   assign bus.word_read    = word_read_q;
   assign bus.word_counter = word_counter_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         word_read_q    <= 1'b0;
         word_counter_q <= '0;
         remaining_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
`ifdef WB_STREAM_PREFETCH_EN
         slot_q         <= '0;
         slot_full_q    <= 1'b0;
         total_words_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  if (bus.num_elems == 32'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q        <= FETCH;
                     remaining_q    <= bus.num_elems;
                     word_counter_q <= '0;
                     word_read_q    <= 1'b1;
                     busy_q         <= 1'b1;
                     done_q         <= 1'b0;
`ifdef WB_STREAM_PREFETCH_EN
                     slot_full_q    <= 1'b0;
                     total_words_q  <= words_for_elems(bus.num_elems, ELEMS_PER_WORD);
`endif
                  end
               end
            end

            FETCH: begin
               if (capture) begin
                  word_read_q    <= 1'b0;
                  word_counter_q <= word_counter_q + 32'd1;
                  state_q        <= STREAM;
               end
            end

            STREAM: begin
`ifdef WB_STREAM_PREFETCH_EN
               if (capture) begin
                  word_counter_q <= word_counter_q + 32'd1;
                  word_read_q    <= 1'b0;
                  // On a boundary edge the word goes straight to the
                  // serializer instead of the slot.
                  if (!at_boundary) begin
                     slot_q      <= bus.sram_word_in;
                     slot_full_q <= 1'b1;
                  end
               end else if (!slot_full_q && !word_read_q
                            && (word_counter_q < total_words_q)) begin
                  word_read_q <= 1'b1;
               end
               if (at_boundary && slot_full_q) begin
                  slot_full_q <= 1'b0;
               end
               if (at_boundary && !slot_full_q && !capture) begin
                  state_q     <= FETCH;
                  word_read_q <= 1'b1;
               end
`else
               if (at_boundary) begin
                  state_q     <= FETCH;
                  word_read_q <= 1'b1;
               end
`endif
               if (ser_fire) begin
                  remaining_q <= remaining_q - 32'd1;
               end
               if (at_end) begin
                  state_q     <= DONE;
                  word_read_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
